// File: rtl/tinyalu_pkg.sv
// Shared types and helpers for the TinyALU stimulus generator.
// Holds the ALU operation encoding and the 64-bit LFSR polynomial.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        DRIVE,
        WAIT_DONE,
        CHECK,
        RST,
        FINISH
    } state_t;

    // Galois taps for x^64 + x^63 + x^61 + x^60 + 1
    localparam logic [63:0] LFSR_POLY = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    function automatic operation_t decode_op(input logic [2:0] f);
        operation_t o;
        unique case (f)
            3'b001:         o = add_op;
            3'b010:         o = and_op;
            3'b011:         o = xor_op;
            3'b100:         o = mul_op;
            3'b110, 3'b111: o = rst_op;
            default:        o = no_op;
        endcase
        return o;
    endfunction

    function automatic logic is_arith(input operation_t o);
        return (o == add_op) || (o == and_op) ||
               (o == xor_op) || (o == mul_op);
    endfunction

endpackage

// File: rtl/tinyalu_lfsr64.sv
// 64-bit Galois LFSR; exposes the low bits of the value it steps to next
// so the caller can register fields in the same cycle the LFSR advances.
module tinyalu_lfsr64
    import tinyalu_pkg::*;
#(
    parameter logic [63:0] SEED  = 64'h1,
    parameter int          OUT_W = 23
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    output logic [OUT_W-1:0] nxt
);

    localparam logic [63:0] INIT = (SEED == 64'h0) ? 64'h1 : SEED;

    logic [63:0] lfsr_q;
    logic [63:0] lfsr_d;
    logic [63:0] nxt_full;

    assign nxt_full = lfsr_step(lfsr_q);
    assign nxt      = nxt_full[OUT_W-1:0];

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = INIT;
        end else if (step) begin
            lfsr_d = nxt_full;
        end
    end

    always_ff @(posedge clk) begin
        lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/tinyalu_stim_gen.sv
// Random stimulus generator and result checker for the TinyALU.
// Drives one LFSR-chosen operation at a time and counts wrong results.
module tinyalu_stim_gen
    import tinyalu_pkg::*;
#(
    parameter int          DATA_W     = 8,
    parameter int          NUM_TXN    = 1000,
    parameter logic [63:0] SEED       = 64'h1,
    parameter int          TIMEOUT    = 64,
    parameter int          RST_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    output logic [DATA_W-1:0]     A,
    output logic [DATA_W-1:0]     B,
    output logic [2:0]            op,
    output logic                  start,
    output logic                  dut_reset,
    input  logic                  done,
    input  logic [2*DATA_W-1:0]   result,
    output logic                  busy,
    output logic [15:0]           txn_cnt,
    output logic [15:0]           mismatch_cnt,
    output logic                  timeout_err,
    output logic                  finished
);

    localparam int W2 = 2 * DATA_W;
    localparam int RW = 7 + W2;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    operation_t        op_q, op_d;
    logic [W2-1:0]     res_q, res_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [15:0]       txn_q, txn_d;
    logic [15:0]       mis_q, mis_d;
    logic              tmo_q, tmo_d;

    logic [RW-1:0]     lfsr_nxt;
    logic              lfsr_step_en;
    logic [DATA_W-1:0] a_gen;
    logic [DATA_W-1:0] b_gen;
    logic [W2-1:0]     expected;

    tinyalu_lfsr64 #(
        .SEED  (SEED),
        .OUT_W (RW)
    ) u_lfsr (
        .clk  (clk),
        .load (reset),
        .step (lfsr_step_en),
        .nxt  (lfsr_nxt)
    );

    // Corner operands (all zeros / all ones) are forced half the time
    always_comb begin
        unique case (lfsr_nxt[4:3])
            2'b00:   a_gen = '0;
            2'b11:   a_gen = '1;
            default: a_gen = lfsr_nxt[7+:DATA_W];
        endcase
        unique case (lfsr_nxt[6:5])
            2'b00:   b_gen = '0;
            2'b11:   b_gen = '1;
            default: b_gen = lfsr_nxt[7+DATA_W+:DATA_W];
        endcase
    end

    always_comb begin
        unique case (op_q)
            add_op:  expected = W2'(a_q) + W2'(b_q);
            and_op:  expected = W2'(a_q & b_q);
            xor_op:  expected = W2'(a_q ^ b_q);
            mul_op:  expected = W2'(a_q) * W2'(b_q);
            default: expected = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        res_d        = res_q;
        cnt_d        = cnt_q;
        txn_d        = txn_q;
        mis_d        = mis_q;
        tmo_d        = tmo_q;
        lfsr_step_en = 1'b0;
        unique case (state_q)
            IDLE, FINISH: begin
                if (run) begin
                    state_d = GEN;
                    txn_d   = '0;
                    mis_d   = '0;
                    tmo_d   = 1'b0;
                end
            end
            GEN: begin
                lfsr_step_en = 1'b1;
                op_d         = decode_op(lfsr_nxt[2:0]);
                a_d          = a_gen;
                b_d          = b_gen;
                state_d      = DRIVE;
            end
            DRIVE: begin
                cnt_d = '0;
                if (op_q == rst_op) begin
                    state_d = RST;
                end else if (op_q == no_op) begin
                    state_d = CHECK;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    res_d   = result;
                    state_d = CHECK;
                end else if (cnt_q == 32'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RST: begin
                if (cnt_q == 32'(RST_CYCLES - 1)) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            CHECK: begin
                if (is_arith(op_q) && (res_q != expected) &&
                    (mis_q != 16'hFFFF)) begin
                    mis_d = mis_q + 16'd1;
                end
                txn_d   = txn_q + 16'd1;
                state_d = (txn_d == 16'(NUM_TXN)) ? FINISH : GEN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= no_op;
            res_q   <= '0;
            cnt_q   <= '0;
            txn_q   <= '0;
            mis_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            txn_q   <= txn_d;
            mis_q   <= mis_d;
            tmo_q   <= tmo_d;
        end
    end

    // no_op still pulses start for its single DRIVE cycle
    assign start = ((state_q == DRIVE) && (op_q != rst_op)) ||
                   (state_q == WAIT_DONE);

    assign dut_reset    = (state_q == RST);
    assign busy         = (state_q != IDLE) && (state_q != FINISH);
    assign finished     = (state_q == FINISH);
    assign A            = a_q;
    assign B            = b_q;
    assign op           = op_q;
    assign txn_cnt      = txn_q;
    assign mismatch_cnt = mis_q;
    assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_tinyalu_stim_gen.sv
// Directed bench for the TinyALU stimulus generator with a modelled ALU
// responder; instance 2 exercises the 16-bit all-ones multiply.
module tb_tinyalu_stim_gen;

    localparam logic [63:0] SEED1 = 64'h3C6E_F372_FE94_F82E;
    localparam logic [63:0] SEED2 = 64'h0000_0000_0000_00F8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;
    logic run2 = 1'b0;

    logic [7:0]  a1, b1;
    logic [2:0]  op1;
    logic        start1, dres1, busy1, tmo1, fin1;
    logic        done1 = 1'b0;
    logic [15:0] result1 = '0;
    logic [15:0] txn1, mis1;

    logic [15:0] a2, b2;
    logic [2:0]  op2;
    logic        start2, dres2, busy2, tmo2, fin2;
    logic        done2 = 1'b0;
    logic [31:0] result2 = 32'hFFFE_0001;
    logic [15:0] txn2, mis2;

    int checks = 0;
    int errors = 0;
    int mode = 0;

    logic [2:0] m_op [64];
    logic [7:0] m_a  [64];
    logic [7:0] m_b  [64];
    logic [18:0] rec [$];

    always #5 clk = ~clk;

    tinyalu_stim_gen #(
        .DATA_W(8), .NUM_TXN(16), .SEED(SEED1),
        .TIMEOUT(64), .RST_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .run(run),
        .A(a1), .B(b1), .op(op1), .start(start1),
        .dut_reset(dres1), .done(done1), .result(result1),
        .busy(busy1), .txn_cnt(txn1), .mismatch_cnt(mis1),
        .timeout_err(tmo1), .finished(fin1)
    );

    tinyalu_stim_gen #(
        .DATA_W(16), .NUM_TXN(1), .SEED(SEED2),
        .TIMEOUT(64), .RST_CYCLES(2)
    ) dut16 (
        .clk(clk), .reset(reset), .run(run2),
        .A(a2), .B(b2), .op(op2), .start(start2),
        .dut_reset(dres2), .done(done2), .result(result2),
        .busy(busy2), .txn_cnt(txn2), .mismatch_cnt(mis2),
        .timeout_err(tmo2), .finished(fin2)
    );

    function automatic logic [63:0] mstep(input logic [63:0] s);
        logic fb;
        fb = s[0];
        s = {1'b0, s[63:1]};
        if (fb) begin
            s[63] = ~s[63];
            s[62] = ~s[62];
            s[60] = ~s[60];
            s[59] = ~s[59];
        end
        return s;
    endfunction

    function automatic logic [2:0] mop(input logic [2:0] f);
        if (f == 3'b101) return 3'b000;
        if (f == 3'b110) return 3'b111;
        return f;
    endfunction

    function automatic logic [7:0] msel(input logic [1:0] s,
                                        input logic [7:0] d);
        if (s == 2'b00) return 8'h00;
        if (s == 2'b11) return 8'hFF;
        return d;
    endfunction

    function automatic logic [15:0] alu(input logic [2:0] o,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
        case (o)
            3'b001:  return {8'h00, a} + {8'h00, b};
            3'b010:  return {8'h00, a & b};
            3'b011:  return {8'h00, a ^ b};
            3'b100:  return {8'h00, a} * {8'h00, b};
            default: return 16'h0000;
        endcase
    endfunction

    // ALU model for instance 1: mode 0 correct, 1 corrupted, 2 silent
    int  rcnt1 = 0;
    logic pend1 = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            pend1 <= 1'b0;
            done1 <= 1'b0;
        end else if (done1) begin
            done1 <= 1'b0;
        end else if (pend1) begin
            if (rcnt1 == 2) begin
                pend1   <= 1'b0;
                done1   <= 1'b1;
                result1 <= alu(op1, a1, b1) ^
                           ((mode == 1) ? 16'h0001 : 16'h0000);
            end else begin
                rcnt1 <= rcnt1 + 1;
            end
        end else if (start1 && mode != 2 &&
                     op1 inside {3'b001, 3'b010, 3'b011, 3'b100}) begin
            pend1 <= 1'b1;
            rcnt1 <= 0;
        end
    end

    int  rcnt2 = 0;
    logic pend2 = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            pend2 <= 1'b0;
            done2 <= 1'b0;
        end else if (done2) begin
            done2 <= 1'b0;
        end else if (pend2) begin
            if (rcnt2 == 2) begin
                pend2 <= 1'b0;
                done2 <= 1'b1;
            end else begin
                rcnt2 <= rcnt2 + 1;
            end
        end else if (start2) begin
            pend2 <= 1'b1;
            rcnt2 <= 0;
        end
    end

    // Each transaction shows exactly one rising edge of start or dut_reset
    logic s_prev = 1'b0;
    logic r_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            rec.delete();
        end else if ((start1 && !s_prev) || (dres1 && !r_prev)) begin
            rec.push_back({op1, a1, b1});
        end
        s_prev <= start1;
        r_prev <= dres1;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic wait_fin(input string tag);
        int n = 0;
        while (!fin1 && n < 2000) begin
            tick();
            n++;
        end
        chk({tag, "_finished"}, fin1, 1);
    endtask

    initial begin
        logic [63:0] ms;
        int dr, st, run_len, exp_mis;
        logic tmo_early;

        ms = SEED1;
        for (int i = 0; i < 64; i++) begin
            ms = mstep(ms);
            m_op[i] = mop(ms[2:0]);
            m_a[i]  = msel(ms[4:3], ms[14:7]);
            m_b[i]  = msel(ms[6:5], ms[22:15]);
        end

        reset = 1'b1;
        tick(3);
        chk("rst_start", start1, 0);
        chk("rst_dut_reset", dres1, 0);
        chk("rst_abop", {a1, b1, op1}, 0);
        chk("rst_txn", txn1, 0);
        chk("rst_mis", mis1, 0);
        chk("rst_flags", {tmo1, fin1, busy1}, 0);
        reset = 1'b0;
        tick();

        // 16-bit all-ones multiply
        run2 = 1'b1;
        tick();
        run2 = 1'b0;
        tick();
        chk("w16_operands", {a2, b2}, 32'hFFFF_FFFF);
        chk("w16_op", op2, 3'b100);
        chk("w16_start", start2, 1);
        begin
            int n = 0;
            while (!fin2 && n < 100) begin
                tick();
                n++;
            end
        end
        chk("w16_finished", fin2, 1);
        chk("w16_mis", mis2, 0);
        chk("w16_txn", txn2, 1);

        // Run 1: correct responder, first op is rst_op
        pulse_run();
        tick();
        chk("first_op", op1, 3'b111);
        dr = 0;
        st = 0;
        for (int i = 0; i < 20 && txn1 == 0; i++) begin
            if (start1) st++;
            if (dres1) dr++;
            tick();
        end
        chk("rstop_len", dr, 2);
        chk("rstop_start", st, 0);
        chk("rstop_txn", txn1, 1);
        wait_fin("run1");
        chk("run1_txn", txn1, 16);
        chk("run1_mis", mis1, 0);
        chk("run1_tmo", tmo1, 0);
        chk("run1_busy", busy1, 0);
        chk("run1_reccount", rec.size(), 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("run1_seq%0d", i), rec[i],
                {m_op[i], m_a[i], m_b[i]});

        // Run 2: corrupted results, LFSR continues from run 1
        mode = 1;
        exp_mis = 0;
        for (int i = 16; i < 32; i++)
            if (m_op[i] inside {3'b001, 3'b010, 3'b011, 3'b100})
                exp_mis++;
        pulse_run();
        chk("run2_cleared", {txn1, mis1}, 0);
        wait_fin("run2");
        chk("run2_txn", txn1, 16);
        chk("run2_mis", mis1, exp_mis);
        chk("run2_seq16", rec[16], {m_op[16], m_a[16], m_b[16]});

        // Run 3: responder silent, expect timeout
        mode = 2;
        pulse_run();
        run_len = 0;
        tmo_early = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (start1) begin
                run_len++;
                if (run_len == 65) tmo_early = tmo1;
            end else begin
                if (run_len > 1) break;
                run_len = 0;
            end
            tick();
        end
        chk("tmo_start_len", run_len, 65);
        chk("tmo_not_early", tmo_early, 0);
        chk("tmo_err", tmo1, 1);
        chk("tmo_finished", fin1, 1);
        chk("tmo_start_low", start1, 0);

        // Reset in WAIT_DONE, then rerun the same sequence
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick();
        pulse_run();
        run_len = 0;
        for (int i = 0; i < 500 && run_len < 5; i++) begin
            run_len = start1 ? run_len + 1 : 0;
            if (run_len < 5) tick();
        end
        chk("abort_in_wait", run_len, 5);
        reset = 1'b1;
        tick();
        chk("abort_start", start1, 0);
        chk("abort_busy", busy1, 0);
        chk("abort_counts", {txn1, mis1}, 0);
        chk("abort_flags", {tmo1, fin1}, 0);
        reset = 1'b0;
        mode = 0;
        tick();
        pulse_run();
        wait_fin("rerun");
        chk("rerun_txn", txn1, 16);
        chk("rerun_mis", mis1, 0);
        chk("rerun_reccount", rec.size(), 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("rerun_seq%0d", i), rec[i],
                {m_op[i], m_a[i], m_b[i]});

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
